lime_mc_core: RTL

//  Parametrised successor to the 16-bit multi-cycle Lime processor top: a multi-cycle core with

---
 rtl/lime_mc_core_if.sv | 46 ++++
 rtl/lime_mc_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lime_mc_core_if.sv
//----------------------------------------------------------------------------
// lime_mc_core_if
//
// Purpose : word-addressed memory bus between the Lime multi-cycle core and
//           its instruction/data memory wrapper. A request is held (with a
//           stable address, direction and store data) until the memory
//           answers with mem_ack. The memory may answer in the same cycle.
//
// Signals : mem_req    core -> mem  access request, held until mem_ack
//           mem_we     core -> mem  1 = write, 0 = read
//           mem_addr   core -> mem  word address (ADDR_W)
//           mem_wdata  core -> mem  store data (DATA_W)
//           mem_rdata  mem  -> core read data, valid while mem_ack = 1
//           mem_ack    mem  -> core completes the current request
//
// Modports: master (core side), slave (memory side)
//----------------------------------------------------------------------------
interface lime_mc_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lime_mc_core.sv
//----------------------------------------------------------------------------
// lime_mc_core
//
// Purpose : parametrised multi-cycle Lime processor. Every instruction walks
//           FETCH -> DECODE -> EXEC and then, depending on the opcode, MEM,
//           WB, back to FETCH or into HALT. Instruction and data memory sit
//           behind a req/ack handshake, so any number of wait states works.
//           Branching is compare-and-branch (BEQ / signed BLT).
//
// Ports   : CLK          clock, rising edge
//           reset_n      asynchronous active-low reset
//           mem          memory bus (lime_mc_core_if.master)
//           main_input   value sampled by IN
//           main_output  register written by OUT
//           halted       core is in HALT (left only by reset)
//           state_dbg    current FSM state encoding
//
// Build option: define LIME_CYCLE_CNT_EN to add a 32-bit free-running cycle
//           counter (frozen while halted) and the RDCYC instruction (op C).
//           Without it op C behaves as a 3-cycle NOP.
//----------------------------------------------------------------------------
module lime_mc_core #(
    parameter int          DATA_W   = 16,
    parameter int          NREGS    = 8,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    lime_mc_core_if.master        mem,
    input  logic [DATA_W-1:0]     main_input,
    output logic [DATA_W-1:0]     main_output,
    output logic                  halted,
    output logic [2:0]            state_dbg
);

    localparam int                IDX_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_ADDI  = 4'h4,
        OP_LW    = 4'h5,
        OP_SW    = 4'h6,
        OP_BEQ   = 4'h7,
        OP_BLT   = 4'h8,
        OP_IN    = 4'h9,
        OP_OUT   = 4'hA,
        OP_JAL   = 4'hB,
        OP_RDCYC = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HALT  = 4'hF
    } op_e;

    // Register indices are taken modulo NREGS so any 3-bit field is legal.
    function automatic logic [IDX_W-1:0] reg_idx(input logic [2:0] field);
        return IDX_W'(32'(field) % NREGS);
    endfunction

    // Architectural and pipeline-less datapath state
    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_main_output;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [NREGS];

    // Registered bus outputs
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Instruction fields
    op_e               w_op;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_ra_idx;
    logic [IDX_W-1:0]  w_rb_idx;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_addr_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic [ADDR_W-1:0] w_next_pc;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_b_from_rd;

    assign w_op        = op_e'(r_ir[15:12]);
    assign w_rd_idx    = reg_idx(r_ir[11:9]);
    assign w_ra_idx    = reg_idx(r_ir[8:6]);
    assign w_rb_idx    = reg_idx(r_ir[5:3]);
    assign w_imm       = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_addr_sum  = r_a + w_imm;
    assign w_wb_data   = (w_op == OP_LW) ? r_mdr : r_alu;
    // SW stores rd and the branches compare rd, so B comes from rd for them.
    assign w_b_from_rd = (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_BLT);

`ifdef LIME_CYCLE_CNT_EN
    logic [31:0] r_cyc;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc <= '0;
        end else if (!r_halted) begin
            r_cyc <= r_cyc + 32'd1;
        end
    end
`endif

    // ALU result and next PC, both consumed in EXEC. r_pc already holds PC+1.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_alu_res = '0;
        w_next_pc = r_pc;
        case (w_op)
            OP_ADD:                 w_alu_res = r_a + r_b;
            OP_SUB:                 w_alu_res = r_a - r_b;
            OP_AND:                 w_alu_res = r_a & r_b;
            OP_OR:                  w_alu_res = r_a | r_b;
            OP_ADDI, OP_LW, OP_SW:  w_alu_res = w_addr_sum;
            OP_IN:                  w_alu_res = main_input;
            OP_JAL: begin
                w_alu_res = DATA_W'(r_pc);
                w_next_pc = w_addr_sum[ADDR_W-1:0];
            end
            OP_BEQ: begin
                if (r_b == r_a) w_next_pc = r_pc + w_imm[ADDR_W-1:0];
            end
            OP_BLT: begin
                if ($signed(r_b) < $signed(r_a)) w_next_pc = r_pc + w_imm[ADDR_W-1:0];
            end
`ifdef LIME_CYCLE_CNT_EN
            OP_RDCYC:               w_alu_res = DATA_W'(r_cyc);
`endif
            default: ;
        endcase
    end

    // Register file; r0 is never written, so it always reads zero.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this small register file is architecturally cleared by reset, so
            // it is reset like plain flops; a real RAM array would be left unreset.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if ((r_state == S_WB) && (w_rd_idx != '0)) begin
            r_regs[w_rd_idx] <= w_wb_data;
        end
    end

    // Main control FSM with registered bus and status outputs.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_pc          <= PC_INIT;
            r_ir          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_alu         <= '0;
            r_mdr         <= '0;
            r_main_output <= '0;
            r_halted      <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= PC_INIT;
            r_mem_wdata   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register
            // here sees the pre-edge values of all the others.
            case (r_state)
                S_FETCH: begin
                    if (r_mem_req && mem.mem_ack) begin
                        r_ir      <= mem.mem_rdata[15:0];
                        r_pc      <= r_pc + ADDR_W'(1);
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end else begin
                        // Only the first fetch after reset arrives here with req low.
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                    end
                end

                S_DECODE: begin
                    r_a     <= r_regs[w_ra_idx];
                    r_b     <= w_b_from_rd ? r_regs[w_rd_idx] : r_regs[w_rb_idx];
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    r_alu <= w_alu_res;
                    r_pc  <= w_next_pc;
                    if (w_op == OP_OUT) r_main_output <= r_a;
                    case (w_op)
                        OP_LW, OP_SW: begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= (w_op == OP_SW);
                            r_mem_addr  <= w_addr_sum[ADDR_W-1:0];
                            r_mem_wdata <= r_b;
                            r_state     <= S_MEM;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_IN, OP_JAL: begin
                            r_state <= S_WB;
                        end
`ifdef LIME_CYCLE_CNT_EN
                        OP_RDCYC: begin
                            r_state <= S_WB;
                        end
`endif
                        OP_HALT: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: begin
                            // Branches, OUT and NOPs finish here; start the next fetch.
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_next_pc;
                            r_state    <= S_FETCH;
                        end
                    endcase
                end

                S_MEM: begin
                    if (r_mem_req && mem.mem_ack) begin
                        if (r_mem_we) begin
                            // Store done: fetch back-to-back, req stays high.
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_pc;
                            r_state    <= S_FETCH;
                        end else begin
                            r_mdr     <= mem.mem_rdata;
                            r_mem_req <= 1'b0;
                            r_state   <= S_WB;
                        end
                    end
                end

                S_WB: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_pc;
                    r_state    <= S_FETCH;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign main_output   = r_main_output;
    assign halted        = r_halted;
    assign state_dbg     = r_state;

endmodule
